// File: rtl/processor_config.sv
// Processor-wide configuration shared by the processor and its stream consumers.
// OUT_WIDTH is the width of the processor's output spike packet.
package processor_config;
   localparam int OUT_WIDTH = 4;
endpackage

// File: rtl/spike_counter_pkg.sv
// Shared types and defaults for the spike counter: FSM state, default widths,
// and the {index, count} result beat layout.
package spike_counter_pkg;
   typedef enum logic {
      ACCUM = 1'b0,
      DRAIN = 1'b1
   } sc_state_e;

   localparam int CNT_WIDTH_DEF  = 8;
   localparam int WINDOW_LEN_DEF = 16;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int IDX_WIDTH_DEF = idx_width(processor_config::OUT_WIDTH);

   // Result beat at the default configuration; index occupies the MSBs.
   typedef struct packed {
      logic [IDX_WIDTH_DEF-1:0] idx;
      logic [CNT_WIDTH_DEF-1:0] count;
   } sc_beat_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// clr_i wins over inc_i when both are asserted.
module sat_counter #(
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr_i,
   input  logic                 inc_i,
   output logic [CNT_WIDTH-1:0] cnt_o
);
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != {CNT_WIDTH{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/axis_spike_counter.sv
// Accumulates per-neuron spike counts over a window of timesteps, then drains
// one {index, count} AXIS beat per neuron; input is stalled for the whole drain.
module axis_spike_counter
   import spike_counter_pkg::*;
#(
   parameter int NUM_OUT    = processor_config::OUT_WIDTH,
   parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
   parameter int WINDOW_LEN = WINDOW_LEN_DEF,
   parameter int IDX_WIDTH  = idx_width(NUM_OUT)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_OUT-1:0]             s_axis_tdata,
   input  logic                           s_axis_tvalid,
   output logic                           s_axis_tready,
   input  logic                           window_flush,
   output logic [IDX_WIDTH+CNT_WIDTH-1:0] m_axis_tdata,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic                           m_axis_tlast
);
   localparam int TS_WIDTH = $clog2(WINDOW_LEN + 1);

   typedef struct packed {
      logic [IDX_WIDTH-1:0] idx;
      logic [CNT_WIDTH-1:0] count;
   } beat_t;

   sc_state_e            state_q;
   logic [TS_WIDTH-1:0]  ts_q;
   logic [IDX_WIDTH-1:0] idx_q;
   logic                 s_rdy_q;
   logic                 m_vld_q;
   logic                 m_last_q;

   logic [CNT_WIDTH-1:0] cnt [NUM_OUT];
   logic                 s_fire;
   logic                 m_fire;
   logic                 last_idx;
   logic                 next_last;
   logic                 win_full;
   logic                 cnt_clr;
   beat_t                beat;

   assign s_fire    = (state_q == ACCUM) && s_axis_tvalid;
   assign m_fire    = (state_q == DRAIN) && m_axis_tready;
   assign last_idx  = (idx_q == IDX_WIDTH'(NUM_OUT - 1));
   assign next_last = ((idx_q + 1'b1) == IDX_WIDTH'(NUM_OUT - 1));
   assign win_full  = (ts_q == TS_WIDTH'(WINDOW_LEN - 1));
   assign cnt_clr   = m_fire && last_idx;

   for (genvar g = 0; g < NUM_OUT; g++) begin : g_cnt
      sat_counter #(
         .CNT_WIDTH(CNT_WIDTH)
      ) u_cnt (
         .clk   (clk),
         .rst   (rst),
         .clr_i (cnt_clr),
         .inc_i (s_fire && s_axis_tdata[g]),
         .cnt_o (cnt[g])
      );
   end

   // Handshake flags are registered alongside the state so they change only on edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ACCUM;
         ts_q     <= '0;
         idx_q    <= '0;
         s_rdy_q  <= 1'b1;
         m_vld_q  <= 1'b0;
         m_last_q <= 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (s_fire) begin
                  ts_q <= ts_q + 1'b1;
               end
               if ((s_fire && win_full) || window_flush) begin
                  state_q  <= DRAIN;
                  s_rdy_q  <= 1'b0;
                  m_vld_q  <= 1'b1;
                  m_last_q <= (NUM_OUT == 1);
               end
            end
            DRAIN: begin
               if (m_fire) begin
                  if (last_idx) begin
                     state_q  <= ACCUM;
                     ts_q     <= '0;
                     idx_q    <= '0;
                     s_rdy_q  <= 1'b1;
                     m_vld_q  <= 1'b0;
                     m_last_q <= 1'b0;
                  end else begin
                     idx_q    <= idx_q + 1'b1;
                     m_last_q <= next_last;
                  end
               end
            end
            default: state_q <= ACCUM;
         endcase
      end
   end

   assign beat.idx      = idx_q;
   assign beat.count    = cnt[idx_q];
   assign s_axis_tready = s_rdy_q;
   assign m_axis_tvalid = m_vld_q;
   assign m_axis_tlast  = m_last_q;
   assign m_axis_tdata  = m_vld_q ? beat : '0;
endmodule

// File: tb/tb_axis_spike_counter.sv
// Bench for axis_spike_counter: a 4/3/4 instance driven by a vector table, hand
// sequences and random windows, plus a 4/2/8 instance for saturation.
module tb_axis_spike_counter;
   localparam int N   = 4;
   localparam int CW  = 3;
   localparam int WL  = 4;
   localparam int IW  = 2;
   localparam int CW2 = 2;
   localparam int WL2 = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst;
   logic [N-1:0]   s_tdata;
   logic           s_tvalid, s_tready, flush;
   logic [IW+CW-1:0] m_tdata;
   logic           m_tvalid, m_tready, m_tlast;

   logic [N-1:0]   s2_tdata;
   logic           s2_tvalid, s2_tready, flush2;
   logic [IW+CW2-1:0] m2_tdata;
   logic           m2_tvalid, m2_tready, m2_tlast;

   int total = 0;
   int bad   = 0;

   axis_spike_counter #(.NUM_OUT(N), .CNT_WIDTH(CW), .WINDOW_LEN(WL), .IDX_WIDTH(IW)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .window_flush(flush),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .m_axis_tlast(m_tlast)
   );

   axis_spike_counter #(.NUM_OUT(N), .CNT_WIDTH(CW2), .WINDOW_LEN(WL2), .IDX_WIDTH(IW)) dut_sat (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s2_tdata), .s_axis_tvalid(s2_tvalid), .s_axis_tready(s2_tready),
      .window_flush(flush2),
      .m_axis_tdata(m2_tdata), .m_axis_tvalid(m2_tvalid), .m_axis_tready(m2_tready),
      .m_axis_tlast(m2_tlast)
   );

   typedef struct packed {
      logic [2:0]       n;
      logic [3:0][3:0]  beats;
      logic             flush_last;
      logic [3:0][3:0]  exp;
   } win_t;

   win_t tbl [5];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic send(input logic [3:0] d, input logic v, input logic fl);
      @(negedge clk);
      if (v) check("s_tready before beat", {31'd0, s_tready}, 32'd1);
      s_tdata  = d;
      s_tvalid = v;
      flush    = fl;
   endtask

   // Call right after the beat/flush that closes a window has been driven.
   task automatic drain(input logic [3:0][3:0] exp, input int stall, input bit rnd,
                        input bit fl_in_drain, input string tag);
      int idx;
      int cyc;
      logic rdy;
      logic [IW+CW-1:0] e;
      idx = 0;
      cyc = 0;
      @(negedge clk);
      s_tvalid = 1'b0;
      flush    = 1'b0;
      while (idx < N && cyc < 200) begin
         if (cyc < stall) rdy = 1'b0;
         else if (rnd)    rdy = 1'($urandom_range(0, 1));
         else             rdy = 1'b1;
         m_tready = rdy;
         flush    = fl_in_drain && (cyc == 0);
         e = {IW'(idx), CW'(exp[idx])};
         check($sformatf("%s vld idx%0d", tag, idx), {31'd0, m_tvalid}, 32'd1);
         check($sformatf("%s data idx%0d", tag, idx), 32'(m_tdata), 32'(e));
         check($sformatf("%s last idx%0d", tag, idx), {31'd0, m_tlast}, 32'(idx == N - 1));
         check($sformatf("%s s_rdy low idx%0d", tag, idx), {31'd0, s_tready}, 32'd0);
         @(negedge clk);
         if (rdy) idx++;
         cyc++;
      end
      check($sformatf("%s drain completed", tag), 32'(idx), 32'(N));
      m_tready = 1'b1;
      flush    = 1'b0;
      check($sformatf("%s s_rdy after", tag), {31'd0, s_tready}, 32'd1);
      check($sformatf("%s vld after", tag), {31'd0, m_tvalid}, 32'd0);
      @(negedge clk);
      check($sformatf("%s vld stays low", tag), {31'd0, m_tvalid}, 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit fl;
      logic [3:0] d;
      int m [4];
      logic [3:0][3:0] e;

      tbl[0] = '{n: 3'd4, beats: {4'b1011, 4'b0000, 4'b0011, 4'b0001}, flush_last: 1'b0,
                 exp: {4'd1, 4'd0, 4'd2, 4'd3}};
      tbl[1] = '{n: 3'd3, beats: {4'b0000, 4'b0100, 4'b0101, 4'b0101}, flush_last: 1'b1,
                 exp: {4'd0, 4'd3, 4'd0, 4'd2}};
      tbl[2] = '{n: 3'd0, beats: '0, flush_last: 1'b1, exp: '0};
      tbl[3] = '{n: 3'd4, beats: {4'b1000, 4'b1000, 4'b1000, 4'b1000}, flush_last: 1'b0,
                 exp: {4'd4, 4'd0, 4'd0, 4'd0}};
      tbl[4] = '{n: 3'd4, beats: {4'b1111, 4'b0110, 4'b1111, 4'b1001}, flush_last: 1'b1,
                 exp: {4'd3, 4'd3, 4'd3, 4'd3}};

      rst = 1'b1;
      s_tdata = '0; s_tvalid = 1'b0; flush = 1'b0; m_tready = 1'b1;
      s2_tdata = '0; s2_tvalid = 1'b0; flush2 = 1'b0; m2_tready = 1'b1;
      repeat (3) @(negedge clk);
      check("reset s_tready", {31'd0, s_tready}, 32'd1);
      check("reset m_tvalid", {31'd0, m_tvalid}, 32'd0);
      check("reset m_tlast", {31'd0, m_tlast}, 32'd0);
      check("reset m_tdata", 32'(m_tdata), 32'd0);
      check("reset sat m_tvalid", {31'd0, m2_tvalid}, 32'd0);
      check("reset sat s_tready", {31'd0, s2_tready}, 32'd1);
      rst = 1'b0;

      for (int t = 0; t < 5; t++) begin
         if (tbl[t].n == 0) begin
            send(4'b0000, 1'b0, 1'b1);
         end else begin
            for (int k = 0; k < int'(tbl[t].n); k++)
               send(tbl[t].beats[k], 1'b1, tbl[t].flush_last && (k == int'(tbl[t].n) - 1));
         end
         drain(tbl[t].exp, 0, 1'b0, (t == 1), $sformatf("tbl%0d", t));
      end

      for (int k = 0; k < 4; k++) send(tbl[0].beats[k], 1'b1, 1'b0);
      drain(tbl[0].exp, 5, 1'b0, 1'b0, "backpressure");

      for (int k = 0; k < 4; k++) send(4'b0010, 1'b1, 1'b0);
      @(negedge clk);
      s_tvalid = 1'b0;
      check("middrain first beat", 32'(m_tdata), 32'({2'd0, 3'd0}));
      @(negedge clk);
      check("middrain second beat", 32'(m_tdata), 32'({2'd1, 3'd4}));
      @(negedge clk);
      rst = 1'b1;
      m_tready = 1'b0;
      @(negedge clk);
      check("middrain rst m_tvalid", {31'd0, m_tvalid}, 32'd0);
      check("middrain rst s_tready", {31'd0, s_tready}, 32'd1);
      check("middrain rst m_tdata", 32'(m_tdata), 32'd0);
      rst = 1'b0;
      m_tready = 1'b1;
      for (int k = 0; k < 4; k++) send(4'b1000, 1'b1, 1'b0);
      drain({4'd4, 4'd0, 4'd0, 4'd0}, 0, 1'b0, 1'b0, "after rst");

      for (int w = 0; w < 25; w++) begin
         n  = $urandom_range(1, WL);
         fl = (n < WL) ? 1'b1 : 1'($urandom_range(0, 1));
         for (int i = 0; i < N; i++) m[i] = 0;
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) send(4'($urandom), 1'b0, 1'b0);
            d = 4'($urandom);
            send(d, 1'b1, fl && (k == n - 1));
            for (int i = 0; i < N; i++)
               if (d[i]) m[i] = (m[i] + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m[i] + 1;
         end
         for (int i = 0; i < N; i++) e[i] = 4'(m[i]);
         drain(e, $urandom_range(0, 2), 1'b1, 1'b0, $sformatf("rnd%0d", w));
      end

      for (int k = 0; k < WL2; k++) begin
         @(negedge clk);
         check($sformatf("sat s_tready beat%0d", k), {31'd0, s2_tready}, 32'd1);
         s2_tdata  = 4'b1111;
         s2_tvalid = 1'b1;
      end
      @(negedge clk);
      s2_tvalid = 1'b0;
      for (int i = 0; i < N; i++) begin
         check($sformatf("sat vld idx%0d", i), {31'd0, m2_tvalid}, 32'd1);
         check($sformatf("sat data idx%0d", i), 32'(m2_tdata), 32'({IW'(i), 2'd3}));
         check($sformatf("sat last idx%0d", i), {31'd0, m2_tlast}, 32'(i == N - 1));
         @(negedge clk);
      end
      check("sat s_tready after", {31'd0, s2_tready}, 32'd1);
      check("sat m_tvalid after", {31'd0, m2_tvalid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
